// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one 32-bit memory port between the I-cache miss port and the D port.
// One transaction at a time, fully registered outputs, optional watchdog abort with bus_error.
module mem_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CNT_WIDTH      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_read_request,
  input  logic [31:0] i_addr,
  output logic        i_read_response,
  output logic [31:0] i_read_data,
  input  logic        d_read_request,
  input  logic        d_write_request,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_write_data,
  input  logic [3:0]  d_byte_enable,
  output logic        d_response,
  output logic [31:0] d_read_data,
  output logic        mem_read_request,
  output logic        mem_write_request,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_byte_enable,
  input  logic        mem_response,
  input  logic [31:0] mem_read_data,
  output logic        bus_error,
  output logic [1:0]  grant_owner
);

  localparam bit                   WD_EN  = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_WIDTH-1:0] TO_VAL = CNT_WIDTH'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY_I = 2'd1,
    S_BUSY_D = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic                 r_last_d;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_inc;
  logic                 w_d_req;
  logic                 w_busy;
  logic                 w_grant_i;
  logic                 w_grant_d;
  logic                 w_ok;
  logic                 w_timeout;

  logic        r_i_rsp, r_d_rsp, r_bus_err;
  logic [31:0] r_i_data, r_d_data;
  logic        r_mem_rd, r_mem_wr;
  logic [31:0] r_mem_addr, r_mem_wdata;
  logic [3:0]  r_mem_be;
  logic [1:0]  r_grant;

  assign w_d_req   = d_read_request | d_write_request;
  assign w_busy    = (r_state == S_BUSY_I) | (r_state == S_BUSY_D);
  assign w_cnt_inc = r_cnt + CNT_WIDTH'(1);

  // Next state and transaction events; mem_response outside BUSY is never looked at.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_i   = 1'b0;
    w_grant_d   = 1'b0;
    w_ok        = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_read_request && (!w_d_req || r_last_d)) begin
          w_grant_i   = 1'b1;
          w_state_nxt = S_BUSY_I;
        end else if (w_d_req) begin
          w_grant_d   = 1'b1;
          w_state_nxt = S_BUSY_D;
        end
      end
      S_BUSY_I, S_BUSY_D: begin
        if (mem_response) begin
          w_ok        = 1'b1;
          w_state_nxt = S_DONE;
        end else if (WD_EN && (w_cnt_inc == TO_VAL)) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_d    <= 1'b1;
      r_cnt       <= '0;
      r_i_rsp     <= 1'b0;
      r_d_rsp     <= 1'b0;
      r_bus_err   <= 1'b0;
      r_i_data    <= '0;
      r_d_data    <= '0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= 4'h0;
      r_grant     <= 2'b00;
    end else begin
      r_i_rsp   <= 1'b0;
      r_d_rsp   <= 1'b0;
      r_bus_err <= 1'b0;
      if (w_grant_i) begin
        r_last_d    <= 1'b0;
        r_cnt       <= '0;
        r_mem_rd    <= 1'b1;
        r_mem_wr    <= 1'b0;
        r_mem_addr  <= i_addr;
        r_mem_wdata <= '0;
        r_mem_be    <= 4'hF;
        r_grant     <= 2'b01;
      end else if (w_grant_d) begin
        // Write wins if the D side raises both strobes.
        r_last_d    <= 1'b1;
        r_cnt       <= '0;
        r_mem_rd    <= ~d_write_request;
        r_mem_wr    <= d_write_request;
        r_mem_addr  <= d_addr;
        r_mem_wdata <= d_write_data;
        r_mem_be    <= d_write_request ? d_byte_enable : 4'hF;
        r_grant     <= 2'b10;
      end else if (w_ok || w_timeout) begin
        r_mem_rd  <= 1'b0;
        r_mem_wr  <= 1'b0;
        r_grant   <= 2'b00;
        r_bus_err <= w_timeout;
        if (r_state == S_BUSY_I) begin
          r_i_rsp  <= 1'b1;
          r_i_data <= w_ok ? mem_read_data : 32'h0;
        end else begin
          r_d_rsp  <= 1'b1;
          r_d_data <= (w_ok && !r_mem_wr) ? mem_read_data : 32'h0;
        end
      end else if (WD_EN && w_busy) begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

  assign i_read_response   = r_i_rsp;
  assign i_read_data       = r_i_data;
  assign d_response        = r_d_rsp;
  assign d_read_data       = r_d_data;
  assign mem_read_request  = r_mem_rd;
  assign mem_write_request = r_mem_wr;
  assign mem_addr          = r_mem_addr;
  assign mem_write_data    = r_mem_wdata;
  assign mem_byte_enable   = r_mem_be;
  assign bus_error         = r_bus_err;
  assign grant_owner       = r_grant;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: responses checked against a scoreboard queue of expected pulses.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_read_request;
  logic [31:0] i_addr;
  logic        i_read_response;
  logic [31:0] i_read_data;
  logic        d_read_request, d_write_request;
  logic [31:0] d_addr, d_write_data;
  logic [3:0]  d_byte_enable;
  logic        d_response;
  logic [31:0] d_read_data;
  logic        mem_read_request, mem_write_request;
  logic [31:0] mem_addr, mem_write_data;
  logic [3:0]  mem_byte_enable;
  logic        mem_response;
  logic [31:0] mem_read_data;
  logic        bus_error;
  logic [1:0]  grant_owner;

  typedef struct {
    logic        side;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .i_read_request(i_read_request), .i_addr(i_addr),
    .i_read_response(i_read_response), .i_read_data(i_read_data),
    .d_read_request(d_read_request), .d_write_request(d_write_request),
    .d_addr(d_addr), .d_write_data(d_write_data), .d_byte_enable(d_byte_enable),
    .d_response(d_response), .d_read_data(d_read_data),
    .mem_read_request(mem_read_request), .mem_write_request(mem_write_request),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_byte_enable(mem_byte_enable),
    .mem_response(mem_response), .mem_read_data(mem_read_data),
    .bus_error(bus_error), .grant_owner(grant_owner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic side, input logic [31:0] data, input logic err);
    exp_t e;
    e.side = side;
    e.data = data;
    e.err  = err;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    i_read_request  = 1'b0;
    d_read_request  = 1'b0;
    d_write_request = 1'b0;
    mem_response    = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_grant"}, grant_owner, 0);
    check({tag, "_mem_req"}, {mem_read_request, mem_write_request}, 0);
    check({tag, "_rsp"}, {i_read_response, d_response, bus_error}, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_be"}, mem_byte_enable, 0);
    check({tag, "_rdata"}, i_read_data | d_read_data | mem_write_data, 0);
  endtask

  // Memory side: wait for a strobe, check the latched request, answer after dly cycles.
  task automatic serve(input int dly, input logic [31:0] rdata, input logic [31:0] eaddr,
                       input logic [31:0] ewd, input logic [3:0] ebe, input logic ewr,
                       input bit scramble, output logic [1:0] owner, output int waited);
    waited = 0;
    owner  = 2'b00;
    do begin
      @(negedge clk);
      waited++;
    end while (!(mem_read_request || mem_write_request) && waited < 50);
    check("strobe_seen", 32'(mem_read_request | mem_write_request), 1);
    if (!(mem_read_request || mem_write_request)) return;
    owner = grant_owner;
    check("mem_rd", mem_read_request, !ewr);
    check("mem_wr", mem_write_request, ewr);
    check("mem_addr", mem_addr, eaddr);
    check("mem_be", mem_byte_enable, ebe);
    if (ewr) check("mem_wdata", mem_write_data, ewd);
    if (scramble) begin
      d_addr        = $urandom;
      d_write_data  = $urandom;
      d_byte_enable = 4'hC;
      i_addr        = $urandom;
    end
    repeat (dly) @(negedge clk);
    check("mem_hold_req", {mem_read_request, mem_write_request}, {!ewr, ewr});
    check("mem_hold_addr", mem_addr, eaddr);
    check("mem_hold_be", mem_byte_enable, ebe);
    if (ewr) check("mem_hold_wdata", mem_write_data, ewd);
    mem_response  = 1'b1;
    mem_read_data = rdata;
    @(negedge clk);
    mem_response  = 1'b0;
    mem_read_data = $urandom;
    check("mem_drop", {mem_read_request, mem_write_request}, 0);
    check("done_grant", grant_owner, 0);
  endtask

  // Every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (i_read_response || d_response) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", {i_read_response, d_response}, 0);
      end else begin
        e = sb.pop_front();
        check("rsp_side", {d_response, i_read_response}, e.side ? 2'b10 : 2'b01);
        check("rsp_data", e.side ? d_read_data : i_read_data, e.data);
        check("rsp_err", bus_error, e.err);
      end
    end else if (bus_error) begin
      check("lone_bus_error", bus_error, 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [1:0] own;
    int w, n;
    i_addr        = '0;
    d_addr        = '0;
    d_write_data  = '0;
    d_byte_enable = '0;
    mem_read_data = '0;
    do_reset();
    check_quiet("reset");

    // I read alone
    i_addr = 32'h100;
    push(1'b0, 32'hDEADBEEF, 1'b0);
    i_read_request = 1'b1;
    serve(3, 32'hDEADBEEF, 32'h100, 32'h0, 4'hF, 1'b0, 1'b0, own, w);
    i_read_request = 1'b0;
    check("i_owner", own, 2'b01);
    check("i_latency", w, 1);
    @(negedge clk);
    check("i_idle_grant", grant_owner, 0);

    // D write with requester inputs changing mid-transaction
    d_addr          = 32'h2004;
    d_write_data    = 32'h12345678;
    d_byte_enable   = 4'b0011;
    d_write_request = 1'b1;
    push(1'b1, 32'h0, 1'b0);
    serve(2, 32'hFFFFFFFF, 32'h2004, 32'h12345678, 4'b0011, 1'b1, 1'b1, own, w);
    d_write_request = 1'b0;
    check("d_owner", own, 2'b10);
    @(negedge clk);

    // Stray mem_response in IDLE
    mem_read_data = 32'h55;
    mem_response  = 1'b1;
    @(negedge clk);
    mem_response = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stray_rsp", {i_read_response, d_response}, 0);
      check("stray_grant", grant_owner, 0);
    end

    // Contention: both held, grants alternate starting with I
    do_reset();
    i_addr         = 32'h300;
    d_addr         = 32'h400;
    i_read_request = 1'b1;
    d_read_request = 1'b1;
    for (int k = 0; k < 4; k++) push(k[0], 32'hA0 + k, 1'b0);
    for (int k = 0; k < 4; k++) begin
      serve(2, 32'hA0 + k, k[0] ? 32'h400 : 32'h300, 32'h0, 4'hF, 1'b0, 1'b0, own, w);
      check("cont_owner", own, k[0] ? 2'b10 : 2'b01);
      check("cont_gap", w, (k == 0) ? 1 : 2);
    end
    i_read_request = 1'b0;
    d_read_request = 1'b0;
    @(negedge clk);

    // Timeout: D read, memory silent
    d_addr         = 32'h500;
    d_read_request = 1'b1;
    push(1'b1, 32'h0, 1'b1);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!mem_read_request && w < 20);
    check("to_strobe", mem_read_request, 1);
    n = 0;
    while (mem_read_request && n < 50) begin
      n++;
      @(negedge clk);
    end
    d_read_request = 1'b0;
    check("to_cycles", n, 8);
    check("to_bus_error", {bus_error, d_response}, 2'b11);
    @(negedge clk);

    // I read after the timeout completes normally
    i_addr = 32'h600;
    push(1'b0, 32'hCAFEF00D, 1'b0);
    i_read_request = 1'b1;
    serve(1, 32'hCAFEF00D, 32'h600, 32'h0, 4'hF, 1'b0, 1'b0, own, w);
    i_read_request = 1'b0;
    check("post_to_owner", own, 2'b01);
    @(negedge clk);

    // Reset in BUSY_I, late mem_response afterwards
    i_addr         = 32'h700;
    i_read_request = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!mem_read_request && w < 20);
    check("rst_strobe", mem_read_request, 1);
    reset = 1'b1;
    @(negedge clk);
    reset          = 1'b0;
    i_read_request = 1'b0;
    check_quiet("rst_mid");
    @(negedge clk);
    mem_read_data = 32'hBAD0BAD0;
    mem_response  = 1'b1;
    @(negedge clk);
    mem_response = 1'b0;
    repeat (2) @(negedge clk);
    check_quiet("rst_late");

    // Next request after reset is served normally
    i_addr = 32'h800;
    push(1'b0, 32'h13579BDF, 1'b0);
    i_read_request = 1'b1;
    serve(2, 32'h13579BDF, 32'h800, 32'h0, 4'hF, 1'b0, 1'b0, own, w);
    i_read_request = 1'b0;
    check("post_rst_owner", own, 2'b01);
    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single 32-bit external memory port between the instruction cache's miss port (read-only) and the data-side port (read/write).
- Two-requester round-robin arbiter. Serves exactly one transaction at a time.
- Captures the winner's address and data, drives the memory handshake, and routes the response pulse and read data back to the owner.
- Optional watchdog ends a stalled memory transaction with an error response.

Parameters:
- TIMEOUT_CYCLES, 0, cycles in BUSY before abort; 0 disables the watchdog.
- CNT_WIDTH, 16, width of the watchdog counter; TIMEOUT_CYCLES must fit in it.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- i_read_request  in  1  I-side read request, held until i_read_response.
- i_addr  in  32  I-side word address.
- i_read_response  out  1  one-cycle done pulse.
- i_read_data  out  32  read data, valid with the pulse.
- d_read_request  in  1  D-side read request.
- d_write_request  in  1  D-side write request.
- d_addr  in  32  D-side address.
- d_write_data  in  32  D-side write data.
- d_byte_enable  in  4  D-side byte lanes.
- d_response  out  1  one-cycle done pulse.
- d_read_data  out  32  read data, valid with the pulse.
- mem_read_request  out  1  memory read strobe, level.
- mem_write_request  out  1  memory write strobe, level.
- mem_addr  out  32  latched address.
- mem_write_data  out  32  latched write data.
- mem_byte_enable  out  4  latched byte enables; 4'hF for reads.
- mem_response  in  1  memory done pulse.
- mem_read_data  in  32  valid with mem_response.
- bus_error  out  1  one-cycle pulse, coincident with a timed-out response.
- grant_owner  out  2  00 none, 01 I, 10 D.

Behaviour:
- Clock and reset: reset is synchronous, active-high; clock is clk. All outputs are registered.
- Values under reset:
  - All requests, responses, bus_error and grant_owner are 0; mem_addr, mem_write_data and read data are 0; mem_byte_enable is 4'h0.
  - State is IDLE, the watchdog counter is 0, and last_grant is D, so I wins the first tie.
- States: IDLE, BUSY_I, BUSY_D, DONE.
- IDLE transitions:
  - Only I requesting: go to BUSY_I.
  - Only D requesting: go to BUSY_D.
  - Both requesting: grant the side opposite last_grant, then update last_grant.
  - On grant, latch address, write data and byte enables. Next cycle assert mem_read_request or mem_write_request, and set grant_owner.
- D-side direction:
  - d_write_request has priority over d_read_request if both are high (illegal input, defined outcome: write).
  - Reads drive mem_byte_enable 4'hF.
- BUSY_x:
  - Memory outputs are held stable until mem_response.
  - On mem_response, drop the mem request and go to DONE. Next cycle pulse x's response for exactly one cycle, with read data registered from mem_read_data (writes return 0).
  - Latency: request sampled at edge T → mem request high from T+1 → mem_response at edge N → owner response high in cycle N+1.
- DONE: one turnaround cycle with no grant. The requester drops its request by the next edge; a request still high in IDLE is a new transaction.
- Input changes: requester changes to address or data after grant are ignored. A requester deasserting before its response is illegal and the transaction still completes.
- mem_response while in IDLE or DONE is ignored.
- Watchdog (TIMEOUT_CYCLES>0):
  - The counter is cleared on grant and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES without mem_response: drop the mem request and go to DONE, pulse the owner's response with data 32'h0, and pulse bus_error in the same cycle.
  - mem_response in the same cycle as the timeout counts as normal completion.
- Reset mid-transaction: immediately return to IDLE, deassert the mem request, and suppress any pending response. A late mem_response after reset is ignored.
- No combinational path from any input to any output.

Test Plan:
- I read alone: i_addr=0x100, memory responds 3 cycles after the strobe with 0xDEADBEEF → mem_read_request high with mem_addr=0x100; i_read_response pulses once with 0xDEADBEEF one cycle after mem_response; grant_owner back to 00 after DONE.
- D write: d_addr=0x2004, data 0x12345678, byte enables 4'b0011 → mem_write_request with latched values held stable while d_addr changes mid-transaction; d_response pulses once with d_read_data=0.
- Contention: after reset I and D request together, both held → grants alternate I, D, I, D; each grant is separated by exactly one DONE cycle; each requester's response pulses exactly once per grant.
- Timeout: TIMEOUT_CYCLES=8, D read, memory never responds → mem_read_request drops after 8 BUSY cycles; d_response and bus_error pulse together with d_read_data=0; a subsequent I read completes normally.
- Reset mid-op: assert reset in BUSY_I, then deliver mem_response 2 cycles later → no i_read_response, all outputs 0, state IDLE; next request is granted normally.
- Stray mem_response in IDLE → no response pulse on either side.
